iic_txn_sequencer: RTL and testbench

- Transaction-level sequencer directly upstream of the I2C bit/byte engine.
- Accepts one register-oriented request (7-bit device address, 8-bit register address, read/write, burst length).
- Breaks each request into engine commands: START, address/register/data byte writes, RESTART, reads, STOP.
- Streams write data in and read data out via valid/ready, and reports completion and NACK errors.

---
 rtl/iic_pkg.sv | 34 +++
 rtl/iic_txn_sequencer_if.sv | 40 ++++
 rtl/iic_txn_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_iic_txn_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C transaction sequencer and the byte engine below it:
// engine command codes, sequencer states and the address R/W bit values.
package iic_pkg;

    localparam logic [2:0] CMD_START     = 3'd1;
    localparam logic [2:0] CMD_RESTART   = 3'd2;
    localparam logic [2:0] CMD_STOP      = 3'd3;
    localparam logic [2:0] CMD_WRITE     = 3'd4;
    localparam logic [2:0] CMD_READ_ACK  = 3'd5;
    localparam logic [2:0] CMD_READ_NACK = 3'd6;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_W,
        ST_REG,
        ST_WDATA,
        ST_RESTART,
        ST_DEV_R,
        ST_RDATA,
        ST_STOP,
        ST_FINISH
    } state_e;

    // ISSUE: command being presented (or, in WDATA, awaiting the data byte); WAIT: awaiting i_cmd_done.
    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

endpackage

// File: rtl/iic_txn_sequencer_if.sv
// Request, data-stream and engine-command signals of the transaction sequencer.
// master is the sequencer's view; slave is the view of its surroundings.
interface iic_txn_sequencer_if #(
    parameter int LEN_W = 4
);
    logic             i_req;
    logic [6:0]       i_dev_addr;
    logic [7:0]       i_reg_addr;
    logic             i_rw;
    logic [LEN_W-1:0] i_len;
    logic [7:0]       i_wr_data;
    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [7:0]       o_rd_data;
    logic             o_rd_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [2:0]       o_cmd;
    logic [7:0]       o_cmd_wdata;
    logic             o_cmd_valid;
    logic             i_cmd_ready;
    logic             i_cmd_done;
    logic             i_ack_n;
    logic [7:0]       i_rdata;

    modport master (
        input  i_req, i_dev_addr, i_reg_addr, i_rw, i_len, i_wr_data, i_wr_valid,
        input  i_cmd_ready, i_cmd_done, i_ack_n, i_rdata,
        output o_wr_ready, o_rd_data, o_rd_valid, o_busy, o_done, o_err,
        output o_cmd, o_cmd_wdata, o_cmd_valid
    );

    modport slave (
        output i_req, i_dev_addr, i_reg_addr, i_rw, i_len, i_wr_data, i_wr_valid,
        output i_cmd_ready, i_cmd_done, i_ack_n, i_rdata,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_busy, o_done, o_err,
        input  o_cmd, o_cmd_wdata, o_cmd_valid
    );
endinterface

// File: rtl/iic_txn_sequencer.sv
// Breaks one register-oriented I2C request into START / byte-write / RESTART / read / STOP
// engine commands, streaming write data in and read data out, and reports completion/NACK.
module iic_txn_sequencer
    import iic_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    iic_txn_sequencer_if.master bus
);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic             rw_q, rw_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             cvalid_q, cvalid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ready;
    logic             last;
    logic             write_state;

    assign last        = (cnt_q == LEN_W'(1));
    assign write_state = (state_q == ST_DEV_W) || (state_q == ST_REG) ||
                         (state_q == ST_WDATA) || (state_q == ST_DEV_R);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_ISSUE;
            dev_q      <= '0;
            reg_q      <= '0;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            cmd_q      <= '0;
            wdata_q    <= '0;
            cvalid_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            cvalid_q   <= cvalid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        cvalid_d   = cvalid_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    dev_d    = bus.i_dev_addr;
                    reg_d    = bus.i_reg_addr;
                    rw_d     = bus.i_rw;
                    cnt_d    = (bus.i_len == '0) ? LEN_W'(1) : bus.i_len;
                    err_d    = 1'b0;
                    state_d  = ST_START;
                    phase_d  = PH_ISSUE;
                    cmd_d    = CMD_START;
                    cvalid_d = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default: begin
                if (phase_q == PH_ISSUE) begin
                    if (cvalid_q) begin
                        if (bus.i_cmd_ready) begin
                            cvalid_d = 1'b0;
                            phase_d  = PH_WAIT;
                        end
                    end else if (state_q == ST_WDATA && bus.i_wr_valid) begin
                        // Byte is captured and presented together; valid rises next cycle.
                        wr_ready = 1'b1;
                        wdata_d  = bus.i_wr_data;
                        cmd_d    = CMD_WRITE;
                        cvalid_d = 1'b1;
                    end
                end else if (bus.i_cmd_done) begin
                    phase_d  = PH_ISSUE;
                    cvalid_d = 1'b1;
                    case (state_q)
                        ST_START: begin
                            state_d = ST_DEV_W;
                            cmd_d   = CMD_WRITE;
                            wdata_d = {dev_q, RW_WRITE};
                        end
                        ST_DEV_W: begin
                            state_d = ST_REG;
                            cmd_d   = CMD_WRITE;
                            wdata_d = reg_q;
                        end
                        ST_REG: begin
                            if (rw_q) begin
                                state_d = ST_RESTART;
                                cmd_d   = CMD_RESTART;
                            end else begin
                                state_d  = ST_WDATA;
                                cvalid_d = 1'b0;
                            end
                        end
                        ST_WDATA: begin
                            if (last) begin
                                state_d = ST_STOP;
                                cmd_d   = CMD_STOP;
                            end else begin
                                cnt_d    = cnt_q - LEN_W'(1);
                                cvalid_d = 1'b0;
                            end
                        end
                        ST_RESTART: begin
                            state_d = ST_DEV_R;
                            cmd_d   = CMD_WRITE;
                            wdata_d = {dev_q, RW_READ};
                        end
                        ST_DEV_R: begin
                            state_d = ST_RDATA;
                            cmd_d   = last ? CMD_READ_NACK : CMD_READ_ACK;
                        end
                        ST_RDATA: begin
                            rd_data_d  = bus.i_rdata;
                            rd_valid_d = 1'b1;
                            if (last) begin
                                state_d = ST_STOP;
                                cmd_d   = CMD_STOP;
                            end else begin
                                cnt_d = cnt_q - LEN_W'(1);
                                cmd_d = (cnt_q == LEN_W'(2)) ? CMD_READ_NACK : CMD_READ_ACK;
                            end
                        end
                        ST_STOP: begin
                            state_d  = ST_FINISH;
                            cvalid_d = 1'b0;
                        end
                        default: begin
                            state_d  = ST_IDLE;
                            cvalid_d = 1'b0;
                        end
                    endcase
                    // A NACK on any byte write abandons the rest of the transfer.
                    if (write_state && bus.i_ack_n) begin
                        err_d    = 1'b1;
                        state_d  = ST_STOP;
                        cmd_d    = CMD_STOP;
                        cvalid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign bus.o_done      = (state_q == ST_FINISH);
    assign bus.o_err       = (state_q == ST_FINISH) && err_q;
    assign bus.o_cmd       = cmd_q;
    assign bus.o_cmd_wdata = wdata_q;
    assign bus.o_cmd_valid = cvalid_q;

endmodule

// File: tb/tb_iic_txn_sequencer.sv
// Bench for iic_txn_sequencer: plays the byte engine and the data stream, compares the
// command stream, data and status of each transaction against a request-level model.
module tb_iic_txn_sequencer;
    import iic_pkg::*;

    typedef struct packed {
        logic [2:0] c;
        logic [7:0] d;
    } cmd_t;

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        int         len;
        int         nack;
        int         rstall;
        int         wstall;
        bit         midreq;
        int         e_ncmd;
        bit         e_err;
        int         e_nwr;
        int         e_nrd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] wr_src[16];
    logic [7:0] rd_src[16];
    cmd_t       exp_q[$];
    bit         exp_err;
    int         exp_nw;
    int         exp_nr;

    iic_txn_sequencer_if #(.LEN_W(4)) bus();

    iic_txn_sequencer #(.LEN_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic cmd_t mk(input logic [2:0] c, input logic [7:0] d);
        cmd_t r;
        r.c = c;
        r.d = d;
        return r;
    endfunction

    // Request-level model: lay out the full command plan, then cut it at the NACKed write.
    function automatic void model(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                  input int len, input int nack_idx);
        cmd_t plan[$];
        int   l = (len == 0) ? 1 : len;
        int   w = 0;
        exp_q = {};
        exp_err = 1'b0;
        exp_nw = 0;
        exp_nr = 0;
        plan.push_back(mk(CMD_START, 8'h00));
        plan.push_back(mk(CMD_WRITE, {dev, 1'b0}));
        plan.push_back(mk(CMD_WRITE, rg));
        if (!rw) begin
            for (int k = 0; k < l; k++) plan.push_back(mk(CMD_WRITE, wr_src[k]));
        end else begin
            plan.push_back(mk(CMD_RESTART, 8'h00));
            plan.push_back(mk(CMD_WRITE, {dev, 1'b1}));
            for (int k = 0; k < l; k++)
                plan.push_back(mk((k == l - 1) ? CMD_READ_NACK : CMD_READ_ACK, 8'h00));
        end
        foreach (plan[i]) begin
            exp_q.push_back(plan[i]);
            if (plan[i].c == CMD_READ_ACK || plan[i].c == CMD_READ_NACK) exp_nr++;
            if (plan[i].c == CMD_WRITE) begin
                if (!rw && w >= 2) exp_nw++;
                if (w == nack_idx) begin
                    exp_err = 1'b1;
                    break;
                end
                w++;
            end
        end
        exp_q.push_back(mk(CMD_STOP, 8'h00));
    endfunction

    task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input int len, input int nack_idx, input int rstall, input int wstall,
                           input bit rnd, input bit mid_req, input bit rst_on_rd,
                           output int ncmd, output bit err, output int nwr, output int nrd);
        cmd_t       obs[$];
        logic [7:0] rd_obs[$];
        bit         outstanding = 0, pend = 0, stab_bad = 0, got_done = 0, mid_done = 0;
        bit         aborted = 0, busy_at_done = 0, ackn_next = 0;
        logic [7:0] rdata_next = 8'h00;
        logic [2:0] pc = 3'd0;
        logic [7:0] pd = 8'h00;
        int         cnt_down = 0, vcyc = 0, wv_wait = 0, widx = 0, ridx = 0, cyc = 0, nbad = 0;
        ncmd = 0; err = 0; nwr = 0; nrd = 0;

        @(negedge clk);
        bus.i_req = 1'b1; bus.i_dev_addr = dev; bus.i_reg_addr = rg; bus.i_rw = rw;
        bus.i_len = 4'(len);
        @(negedge clk);
        bus.i_req = 1'b0; bus.i_dev_addr = ~dev; bus.i_reg_addr = ~rg; bus.i_rw = ~rw;
        bus.i_len = 4'd7;
        chk("start_cmd", {bus.o_busy, bus.o_cmd_valid, bus.o_cmd}, {1'b1, 1'b1, CMD_START});

        while (!got_done) begin
            if (bus.o_rd_valid) rd_obs.push_back(bus.o_rd_data);
            if (bus.o_done) begin
                got_done = 1; err = bus.o_err; busy_at_done = bus.o_busy;
                break;
            end
            if (rst_on_rd && rd_obs.size() != 0) begin
                rst = 1'b1; bus.i_cmd_done = 1'b0; bus.i_cmd_ready = 1'b1;
                bus.i_wr_valid = 1'b1; bus.i_req = 1'b0;
                @(negedge clk);
                chk("rst_mid_outs", {bus.o_busy, bus.o_done, bus.o_err, bus.o_cmd_valid,
                    bus.o_rd_valid, bus.o_wr_ready, bus.o_cmd, bus.o_cmd_wdata, bus.o_rd_data}, 64'd0);
                rst = 1'b0; bus.i_wr_valid = 1'b0;
                aborted = 1;
                break;
            end
            if (cyc >= 3000) begin
                chk("timeout", 1, 0);
                aborted = 1;
                break;
            end
            if (pend && (!bus.o_cmd_valid || bus.o_cmd !== pc || bus.o_cmd_wdata !== pd)) stab_bad = 1;
            if (bus.o_busy && !bus.o_cmd_valid && !outstanding) wv_wait++;

            bus.i_cmd_done = 1'b0; bus.i_ack_n = 1'b0; bus.i_rdata = 8'h00;
            if (outstanding) begin
                if (cnt_down == 0) begin
                    bus.i_cmd_done = 1'b1; bus.i_ack_n = ackn_next; bus.i_rdata = rdata_next;
                    outstanding = 0;
                end else cnt_down--;
            end else if (rnd && ($urandom % 8 == 0)) begin
                bus.i_cmd_done = 1'b1; bus.i_ack_n = 1'b1; bus.i_rdata = 8'hEE;
            end

            vcyc = bus.o_cmd_valid ? vcyc + 1 : 0;
            bus.i_cmd_ready = rnd ? ($urandom % 3 != 0) : (vcyc > rstall);
            bus.i_wr_valid = (nwr < 16) && (rnd ? ($urandom % 2 == 1) : (wv_wait > wstall));
            bus.i_wr_data = wr_src[nwr % 16];
            if ((mid_req || (rnd && $urandom % 16 == 0)) && !mid_done && bus.o_busy && obs.size() >= 2) begin
                bus.i_req = 1'b1; mid_done = 1;
            end else bus.i_req = 1'b0;

            #1;
            if (bus.o_wr_ready) begin
                nwr++; wv_wait = 0;
            end
            if (bus.o_cmd_valid && bus.i_cmd_ready) begin
                obs.push_back(mk(bus.o_cmd, bus.o_cmd_wdata));
                outstanding = 1; pend = 0;
                cnt_down = rnd ? int'($urandom % 3) : 1;
                ackn_next = 1'b0;
                if (bus.o_cmd == CMD_WRITE) begin
                    ackn_next = (widx == nack_idx); widx++;
                end
                if (bus.o_cmd == CMD_READ_ACK || bus.o_cmd == CMD_READ_NACK) begin
                    rdata_next = rd_src[ridx % 16]; ridx++;
                end
            end else begin
                pend = bus.o_cmd_valid; pc = bus.o_cmd; pd = bus.o_cmd_wdata;
            end
            cyc++;
            @(negedge clk);
        end
        bus.i_req = 1'b0; bus.i_cmd_done = 1'b0; bus.i_ack_n = 1'b0;
        bus.i_wr_valid = 1'b0; bus.i_cmd_ready = 1'b0;
        ncmd = obs.size();
        nrd = rd_obs.size();
        if (aborted) return;

        model(rw, dev, rg, len, nack_idx);
        chk("ncmd", ncmd, exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i].c !== exp_q[i].c || (obs[i].c == CMD_WRITE && obs[i].d !== exp_q[i].d)) nbad++;
        chk("stream_mismatches", nbad, 0);
        chk("err", err, exp_err);
        chk("done_busy_low", busy_at_done, 0);
        chk("wr_ready_pulses", nwr, exp_nw);
        chk("rd_pulses", nrd, exp_nr);
        nbad = 0;
        for (int i = 0; i < rd_obs.size() && i < exp_nr; i++)
            if (rd_obs[i] !== rd_src[i]) nbad++;
        chk("rd_data_mismatches", nbad, 0);
        chk("cmd_stable", stab_bad, 0);
    endtask

    vec_t tbl[9];
    int   ncmd, nwr, nrd;
    bit   err;

    initial begin
        // rw dev reg len nack rstall wstall midreq | ncmd err nwr nrd
        tbl[0] = '{1'b0, 7'h50, 8'h10, 2,  -1, 0, 0, 1'b0,  6, 1'b0, 2, 0};
        tbl[1] = '{1'b1, 7'h50, 8'h20, 3,  -1, 0, 0, 1'b0,  9, 1'b0, 0, 3};
        tbl[2] = '{1'b0, 7'h50, 8'h10, 2,   0, 0, 0, 1'b0,  3, 1'b1, 0, 0};
        tbl[3] = '{1'b0, 7'h50, 8'h10, 2,  -1, 5, 3, 1'b0,  6, 1'b0, 2, 0};
        tbl[4] = '{1'b1, 7'h2A, 8'h05, 0,  -1, 0, 0, 1'b1,  7, 1'b0, 0, 1};
        tbl[5] = '{1'b0, 7'h7F, 8'hFF, 15,  4, 1, 1, 1'b0,  7, 1'b1, 3, 0};
        tbl[6] = '{1'b1, 7'h01, 8'h80, 4,   2, 0, 0, 1'b1,  6, 1'b1, 0, 0};
        tbl[7] = '{1'b0, 7'h33, 8'h44, 0,  -1, 2, 2, 1'b1,  5, 1'b0, 1, 0};
        tbl[8] = '{1'b1, 7'h50, 8'h00, 15, -1, 0, 0, 1'b0, 21, 1'b0, 0, 15};

        bus.i_req = 1'b0; bus.i_dev_addr = '0; bus.i_reg_addr = '0; bus.i_rw = 1'b0;
        bus.i_len = '0; bus.i_wr_data = '0; bus.i_wr_valid = 1'b0; bus.i_cmd_ready = 1'b0;
        bus.i_cmd_done = 1'b0; bus.i_ack_n = 1'b0; bus.i_rdata = '0;
        for (int k = 0; k < 16; k++) begin
            wr_src[k] = 8'(k * 29 + 7);
            rd_src[k] = 8'((k + 1) * 17);
        end
        wr_src[0] = 8'hA5; wr_src[1] = 8'h3C;

        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.o_busy, bus.o_done, bus.o_err, bus.o_cmd_valid, bus.o_rd_valid,
            bus.o_wr_ready, bus.o_cmd, bus.o_cmd_wdata, bus.o_rd_data}, 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_txn(tbl[i].rw, tbl[i].dev, tbl[i].rg, tbl[i].len, tbl[i].nack, tbl[i].rstall,
                    tbl[i].wstall, 1'b0, tbl[i].midreq, 1'b0, ncmd, err, nwr, nrd);
            chk("tbl_ncmd", ncmd, tbl[i].e_ncmd);
            chk("tbl_err", err, tbl[i].e_err);
            chk("tbl_nwr", nwr, tbl[i].e_nwr);
            chk("tbl_nrd", nrd, tbl[i].e_nrd);
        end

        // Reset in the middle of a read burst, then a fresh request must complete normally.
        run_txn(1'b1, 7'h50, 8'h20, 3, -1, 0, 0, 1'b0, 1'b0, 1'b1, ncmd, err, nwr, nrd);
        run_txn(1'b1, 7'h51, 8'h21, 2, -1, 0, 0, 1'b0, 1'b0, 1'b0, ncmd, err, nwr, nrd);
        chk("after_rst_nrd", nrd, 2);

        for (int t = 0; t < 30; t++) begin
            logic       rw;
            int         len, nk;
            rw = 1'($urandom);
            len = int'($urandom % 16);
            for (int k = 0; k < 16; k++) begin
                wr_src[k] = 8'($urandom);
                rd_src[k] = 8'($urandom);
            end
            nk = ($urandom % 4 == 0) ? int'($urandom % (rw ? 3 : 2 + ((len == 0) ? 1 : len))) : -1;
            run_txn(rw, 7'($urandom), 8'($urandom), len, nk, 0, 0, 1'b1, 1'b0, 1'b0,
                    ncmd, err, nwr, nrd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
